// File: rtl/mainfsm_pkg.sv
// mainfsm_pkg: shared definitions for the multicycle main controller.
//   state_t   - 4-bit state codes, FETCH = 0, codes 11..15 unused
//   SRCA_*    - ALUSrcA encodings
//   SRCB_*    - ALUSrcB encodings
//   RES_*     - ResultSrc encodings
//   OP_*      - instruction op field encodings
//   ctrl_t    - the control word the output decoder drives
package mainfsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] SRCA_RD1  = 2'b00;
  localparam logic [1:0] SRCA_PC   = 2'b01;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       next_pc;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
  } ctrl_t;

endpackage

// File: rtl/mainfsm_outdec.sv
// mainfsm_outdec: purely combinational state -> control word map.
//   state_i - current state code
//   ctrl_o  - control word; any field not set for a state is 0, and any
//             code outside the enum decodes like UNKNOWN (all zero)
module mainfsm_outdec
  import mainfsm_pkg::*;
(
  input  state_t state_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.ir_write   = 1'b1;
        ctrl_o.next_pc    = 1'b1;
        ctrl_o.adr_src    = 1'b0;
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.result_src = RES_ALU;
      end
      S_DECODE: begin
        // PC is already PC+4 here, so PC+4 again gives PC+8 for r15 reads
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.result_src = RES_ALU;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = SRCA_RD1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        ctrl_o.result_src = RES_DATA;
        ctrl_o.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.adr_src    = 1'b1;
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.mem_w      = 1'b1;
      end
      S_EXECUTER: begin
        ctrl_o.alu_src_a = SRCA_RD1;
        ctrl_o.alu_src_b = SRCB_RD2;
        ctrl_o.alu_op    = 1'b1;
      end
      S_EXECUTEI: begin
        ctrl_o.alu_src_a = SRCA_RD1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = 1'b1;
      end
      S_ALUWB: begin
        ctrl_o.result_src = RES_ALUOUT;
        ctrl_o.reg_w      = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a  = SRCA_RD1;
        ctrl_o.alu_src_b  = SRCB_IMM;
        ctrl_o.result_src = RES_ALU;
        ctrl_o.branch     = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mainfsm.sv
// mainfsm: Moore main controller of a multicycle ARM-subset processor.
//   clk, reset            - clock; asynchronous active-high reset to FETCH
//   op, funct             - instr[27:26] and instr[25:20]; sampled only in
//                           DECODE and MEMADR
//   IRWrite .. ALUOp      - control outputs, pure functions of the state
//   state                 - current state code for debug
// The condition unit downstream gates RegW, MemW and Branch.
module mainfsm
  import mainfsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [3:0] state
);

  state_t state_q, state_d;
  ctrl_t  ctrl;

  // funct[4:1] (cmd / S bits) belong to the ALU decoder, not this block
  logic unused_funct;
  assign unused_funct = ^funct[4:1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_DP:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
          OP_MEM:  state_d = S_MEMADR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR:   state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      // MEMWB, MEMWR, ALUWB, BRANCH, UNKNOWN and unused codes return to FETCH
      default:    state_d = S_FETCH;
    endcase
  end

  mainfsm_outdec u_outdec (
    .state_i (state_q),
    .ctrl_o  (ctrl)
  );

  assign IRWrite   = ctrl.ir_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ResultSrc = ctrl.result_src;
  assign NextPC    = ctrl.next_pc;
  assign RegW      = ctrl.reg_w;
  assign MemW      = ctrl.mem_w;
  assign Branch    = ctrl.branch;
  assign ALUOp     = ctrl.alu_op;
  assign state     = state_q;

endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm: self-checking bench for mainfsm. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_mainfsm;
  import mainfsm_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic       IRWrite, AdrSrc, NextPC, RegW, MemW, Branch, ALUOp;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] state;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] exp_q[$];

  mainfsm dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
    .Branch(Branch), .ALUOp(ALUOp), .state(state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // control word {IRWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,NextPC,RegW,MemW,Branch,ALUOp}
  function automatic logic [12:0] dut_ctrl();
    return {IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW, MemW, Branch, ALUOp};
  endfunction

  // Reference control word for each state, taken from the output table.
  function automatic logic [12:0] ref_ctrl(input logic [3:0] s);
    logic ir, adr, npc, rw, mw, br, aop;
    logic [1:0] sa, sb, rs;
    {ir, adr, npc, rw, mw, br, aop} = '0;
    sa = 2'b00; sb = 2'b00; rs = 2'b00;
    case (s)
      S_FETCH:    begin ir = 1; npc = 1; sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      S_DECODE:   begin sa = 2'b01; sb = 2'b10; rs = 2'b10; end
      S_MEMADR:   begin sb = 2'b01; end
      S_MEMRD:    begin adr = 1; end
      S_MEMWB:    begin rs = 2'b01; rw = 1; end
      S_MEMWR:    begin adr = 1; mw = 1; end
      S_EXECUTER: begin aop = 1; end
      S_EXECUTEI: begin sb = 2'b01; aop = 1; end
      S_ALUWB:    begin rw = 1; end
      S_BRANCH:   begin sb = 2'b01; rs = 2'b10; br = 1; end
      default:    ;
    endcase
    return {ir, adr, sa, sb, rs, npc, rw, mw, br, aop};
  endfunction

  // Instruction-level model: the state walk an instruction takes.
  task automatic build_walk(input logic [1:0] i_op, input logic [5:0] i_funct);
    exp_q.delete();
    exp_q.push_back(S_FETCH);
    exp_q.push_back(S_DECODE);
    case (i_op)
      2'b00: begin
        exp_q.push_back(i_funct[5] ? S_EXECUTEI : S_EXECUTER);
        exp_q.push_back(S_ALUWB);
      end
      2'b01: begin
        exp_q.push_back(S_MEMADR);
        if (i_funct[0]) begin
          exp_q.push_back(S_MEMRD);
          exp_q.push_back(S_MEMWB);
        end else begin
          exp_q.push_back(S_MEMWR);
        end
      end
      2'b10: exp_q.push_back(S_BRANCH);
      default: exp_q.push_back(S_UNKNOWN);
    endcase
  endtask

  // ---------------- driver ----------------
  // Walks one instruction from FETCH; called at a falling edge.
  // stop_at >= 0 leaves the walk parked at that step (falling edge).
  task automatic run_instr(input string name, input logic [1:0] i_op,
                           input logic [5:0] i_funct, input int stop_at);
    int rw_cnt = 0, mw_cnt = 0, npc_cnt = 0, exp_len;
    logic [3:0] s;
    build_walk(i_op, i_funct);
    exp_len = exp_q.size();
    for (int i = 0; i < exp_len; i++) begin
      s = exp_q[i];
      check({name, "_state"}, 16'(state), 16'(s));
      check({name, "_ctrl"}, 16'(dut_ctrl()), 16'(ref_ctrl(s)));
      rw_cnt += int'(RegW); mw_cnt += int'(MemW); npc_cnt += int'(NextPC);
      if (i == stop_at) return;
      if (s == S_DECODE || s == S_MEMADR) begin
        op = i_op; funct = i_funct;
      end else begin
        op = 2'($urandom_range(0, 3)); funct = 6'($urandom_range(0, 63));
      end
      @(posedge clk);
      @(negedge clk);
    end
    check({name, "_regw_cnt"}, 16'(rw_cnt),
          16'((i_op == 2'b00 || (i_op == 2'b01 && i_funct[0])) ? 1 : 0));
    check({name, "_memw_cnt"}, 16'(mw_cnt), 16'((i_op == 2'b01 && !i_funct[0]) ? 1 : 0));
    check({name, "_nextpc_cnt"}, 16'(npc_cnt), 16'd1);
  endtask

  task automatic reset_now(input string name);
    reset = 1'b1;
    #1;
    check({name, "_async_state"}, 16'(state), 16'(S_FETCH));
    check({name, "_async_regw"}, 16'(RegW), 16'd0);
    check({name, "_async_memw"}, 16'(MemW), 16'd0);
    check({name, "_async_ctrl"}, 16'(dut_ctrl()), 16'(ref_ctrl(S_FETCH)));
    @(posedge clk);
    @(negedge clk);
    check({name, "_held_state"}, 16'(state), 16'(S_FETCH));
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] r_op;
    logic [5:0] r_funct;
    reset = 1'b1; op = 2'b11; funct = 6'h3f;
    #2;
    check("rst_state", 16'(state), 16'(S_FETCH));
    check("rst_ctrl", 16'(dut_ctrl()), 16'(ref_ctrl(S_FETCH)));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_held_state", 16'(state), 16'(S_FETCH));
    reset = 1'b0;

    run_instr("add_reg", 2'b00, 6'b001000, -1);
    run_instr("add_imm", 2'b00, 6'b101000, -1);
    run_instr("ldr", 2'b01, 6'b011001, -1);
    run_instr("str", 2'b01, 6'b011000, -1);
    run_instr("b", 2'b10, 6'b000000, -1);
    run_instr("undef", 2'b11, 6'b000000, -1);

    for (int k = 0; k < 60; k++) begin
      r_op = 2'($urandom_range(0, 3));
      r_funct = 6'($urandom());
      run_instr("rand", r_op, r_funct, -1);
    end

    // reset in MEMWR (step 3) and in MEMWB (step 4)
    run_instr("str_cut", 2'b01, 6'b011000, 3);
    check("str_cut_memw_before", 16'(MemW), 16'd1);
    reset_now("rst_memwr");
    run_instr("after_rst1", 2'b00, 6'b001000, -1);

    run_instr("ldr_cut", 2'b01, 6'b011001, 4);
    check("ldr_cut_regw_before", 16'(RegW), 16'd1);
    reset_now("rst_memwb");
    run_instr("after_rst2", 2'b10, 6'b000000, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
